// File: rtl/risc16_pkg.sv
// Shared encodings for the RiSC-16 multi-cycle controller and its datapath.
// Opcodes, FSM states, mux/function codes and the control-output bundle.
package risc16_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   localparam logic [1:0] PC_SRC_INC    = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JALR   = 2'd2;

   localparam logic [1:0] ALU_ADD    = 2'd0;
   localparam logic [1:0] ALU_NAND   = 2'd1;
   localparam logic [1:0] ALU_PASS_B = 2'd2;
   localparam logic [1:0] ALU_EQ     = 2'd3;

   localparam logic [1:0] WSEL_ALU = 2'd0;
   localparam logic [1:0] WSEL_MEM = 2'd1;
   localparam logic [1:0] WSEL_LUI = 2'd2;
   localparam logic [1:0] WSEL_PC  = 2'd3;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       mem_addr_sel;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic [1:0] alu_op;
      logic       alu_b_sel;
      logic       rf_we;
      logic [1:0] rf_wsel;
      logic       op_latch;
      logic       retire;
   } ctrl_t;

   // During reset only the PC load is active so the datapath picks up pc_init.
   function automatic ctrl_t ctrl_reset();
      ctrl_t c;
      c       = '0;
      c.pc_we = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/risc16_ctrl_outdec.sv
// Combinational output decode for the RiSC-16 controller FSM.
// Halt suppression is built only when RISC16_HALT_DETECT_EN is defined.
module risc16_ctrl_outdec
   import risc16_pkg::*;
(
   input  logic [2:0] state,
   input  logic [2:0] opcode_q,
   input  logic       alu_eq,
   input  logic       mem_ready,
   input  logic       imm_nz,
   output ctrl_t      ctrl
);

`ifndef RISC16_HALT_DETECT_EN
   logic unused_imm_nz;
   assign unused_imm_nz = imm_nz;
`endif

   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            ctrl.mem_req = 1'b1;
            if (mem_ready) begin
               ctrl.ir_we  = 1'b1;
               ctrl.pc_we  = 1'b1;
               ctrl.pc_src = PC_SRC_INC;
            end
         end
         ST_DECODE: ctrl.op_latch = 1'b1;
         ST_EXEC: begin
            case (opcode_q)
               OP_ADD:  ctrl.alu_op = ALU_ADD;
               OP_NAND: ctrl.alu_op = ALU_NAND;
               OP_ADDI, OP_SW, OP_LW: begin
                  ctrl.alu_op    = ALU_ADD;
                  ctrl.alu_b_sel = 1'b1;
               end
               OP_BEQ: begin
                  ctrl.alu_op = ALU_EQ;
                  if (alu_eq) begin
                     ctrl.pc_we  = 1'b1;
                     ctrl.pc_src = PC_SRC_BRANCH;
                  end
                  ctrl.retire = 1'b1;
               end
               OP_JALR: begin
                  // Old PC+1 and rB are both sampled before this edge, so rA == rB is safe.
                  ctrl.rf_we   = 1'b1;
                  ctrl.rf_wsel = WSEL_PC;
                  ctrl.pc_we   = 1'b1;
                  ctrl.pc_src  = PC_SRC_JALR;
                  ctrl.retire  = 1'b1;
`ifdef RISC16_HALT_DETECT_EN
                  if (imm_nz) begin
                     ctrl.rf_we = 1'b0;
                     ctrl.pc_we = 1'b0;
                  end
`endif
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            ctrl.mem_req      = 1'b1;
            ctrl.mem_addr_sel = 1'b1;
            ctrl.mem_we       = (opcode_q == OP_SW);
            ctrl.retire       = mem_ready && (opcode_q == OP_SW);
         end
         ST_WB: begin
            ctrl.rf_we  = 1'b1;
            ctrl.retire = 1'b1;
            case (opcode_q)
               OP_LUI:  ctrl.rf_wsel = WSEL_LUI;
               OP_LW:   ctrl.rf_wsel = WSEL_MEM;
               default: ctrl.rf_wsel = WSEL_ALU;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/risc16_ctrl.sv
// RiSC-16 multi-cycle control FSM: FETCH, DECODE, EXEC, MEM, WB (+ HALT).
// Define RISC16_HALT_DETECT_EN to stop on JALR with a non-zero immediate.
module risc16_ctrl
   import risc16_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  opcode,
   input  logic        imm_nz,
   input  logic        alu_eq,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic [1:0]  alu_op,
   output logic        alu_b_sel,
   output logic        rf_we,
   output logic [1:0]  rf_wsel,
   output logic        op_latch,
   output logic        retire,
   output logic [15:0] pc_init
);

   logic [2:0] state_q, state_d;
   logic [2:0] opcode_q, opcode_d;
   ctrl_t      dec_ctrl;
   ctrl_t      ctrl;

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      case (state_q)
         ST_FETCH: if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            state_d  = ST_EXEC;
            opcode_d = opcode;
         end
         ST_EXEC: begin
            case (opcode_q)
               OP_SW, OP_LW: state_d = ST_MEM;
               OP_BEQ:       state_d = ST_FETCH;
               OP_JALR: begin
                  state_d = ST_FETCH;
`ifdef RISC16_HALT_DETECT_EN
                  if (imm_nz) state_d = ST_HALT;
`endif
               end
               default:      state_d = ST_WB;
            endcase
         end
         ST_MEM: if (mem_ready) state_d = (opcode_q == OP_LW) ? ST_WB : ST_FETCH;
         ST_WB:  state_d = ST_FETCH;
`ifdef RISC16_HALT_DETECT_EN
         ST_HALT: state_d = ST_HALT;
`endif
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_FETCH;
         opcode_q <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

   risc16_ctrl_outdec u_outdec (
      .state     (state_q),
      .opcode_q  (opcode_q),
      .alu_eq    (alu_eq),
      .mem_ready (mem_ready),
      .imm_nz    (imm_nz),
      .ctrl      (dec_ctrl)
   );

   // Reset overrides combinationally so an in-flight request drops in the same cycle.
   assign ctrl = rst ? ctrl_reset() : dec_ctrl;

   assign mem_req      = ctrl.mem_req;
   assign mem_we       = ctrl.mem_we;
   assign mem_addr_sel = ctrl.mem_addr_sel;
   assign ir_we        = ctrl.ir_we;
   assign pc_we        = ctrl.pc_we;
   assign pc_src       = ctrl.pc_src;
   assign alu_op       = ctrl.alu_op;
   assign alu_b_sel    = ctrl.alu_b_sel;
   assign rf_we        = ctrl.rf_we;
   assign rf_wsel      = ctrl.rf_wsel;
   assign op_latch     = ctrl.op_latch;
   assign retire       = ctrl.retire;
   assign pc_init      = RESET_PC;

endmodule

// File: tb/tb_risc16_ctrl.sv
// Testbench for risc16_ctrl: expected per-cycle traces are generated per instruction
// from the instruction-level timing rules, then applied and compared cycle by cycle.
module tb_risc16_ctrl;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  opcode = 3'd0;
   logic        imm_nz = 1'b0;
   logic        alu_eq = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
   logic [1:0]  pc_src, alu_op;
   logic        alu_b_sel, rf_we;
   logic [1:0]  rf_wsel;
   logic        op_latch, retire;
   logic [15:0] pc_init;

   always #5 clk = ~clk;

   risc16_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .imm_nz(imm_nz), .alu_eq(alu_eq),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .alu_op(alu_op), .alu_b_sel(alu_b_sel), .rf_we(rf_we), .rf_wsel(rf_wsel),
      .op_latch(op_latch), .retire(retire), .pc_init(pc_init)
   );

   typedef struct packed {
      logic       rst;
      logic       mem_ready;
      logic [2:0] opcode;
      logic       alu_eq;
      logic       imm_nz;
   } ins_t;

   typedef struct packed {
      logic        mem_req;
      logic        mem_we;
      logic        mem_addr_sel;
      logic        ir_we;
      logic        pc_we;
      logic [1:0]  pc_src;
      logic [1:0]  alu_op;
      logic        alu_b_sel;
      logic        rf_we;
      logic [1:0]  rf_wsel;
      logic        op_latch;
      logic        retire;
      logic [15:0] pc_init;
   } outs_t;

   typedef struct packed {
      ins_t  i;
      outs_t o;
   } vec_t;

   typedef struct {
      logic [2:0] op;
      int         wf;
      int         wm;
      logic       eq;
      logic       imm;
   } dir_t;

   vec_t  vq[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   string tag = "reset";

   function automatic outs_t quiet();
      outs_t o;
      o = '0;
      o.pc_init = RESET_PC;
      return o;
   endfunction

   function automatic ins_t rnd_in(logic [2:0] op);
      ins_t i;
      i.rst       = 1'b0;
      i.mem_ready = 1'($urandom);
      i.opcode    = op;
      i.alu_eq    = 1'($urandom);
      i.imm_nz    = 1'($urandom);
      return i;
   endfunction

   task automatic push(input ins_t i, input outs_t o);
      vec_t v;
      v.i = i;
      v.o = o;
      vq.push_back(v);
   endtask

   task automatic push_reset();
      ins_t  i;
      outs_t o;
      i = rnd_in(3'($urandom));
      i.rst = 1'b1;
      o = quiet();
      o.pc_we = 1'b1;
      push(i, o);
   endtask

   // Expected cycle trace of one instruction: fetch (+waits), decode, execute, [mem (+waits)], [wb].
   task automatic add_instr(input logic [2:0] op, input int wf, input int wm,
                            input logic eq, input logic imm);
      ins_t  i;
      outs_t o;
      bit    halted;
      bit    to_mem;
      bit    to_wb;
      for (int k = 0; k < wf; k++) begin
         i = rnd_in(3'($urandom)); i.mem_ready = 1'b0;
         o = quiet(); o.mem_req = 1'b1;
         push(i, o);
      end
      i = rnd_in(3'($urandom)); i.mem_ready = 1'b1;
      o = quiet(); o.mem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1; o.pc_src = 2'd0;
      push(i, o);
      i = rnd_in(op);
      o = quiet(); o.op_latch = 1'b1;
      push(i, o);
      i = rnd_in(op); i.alu_eq = eq; i.imm_nz = imm;
      o = quiet();
      to_mem = (op == 3'd4) || (op == 3'd5);
      to_wb  = (op <= 3'd3);
      halted = 1'b0;
      case (op)
         3'd0: o.alu_op = 2'd0;
         3'd2: o.alu_op = 2'd1;
         3'd1, 3'd4, 3'd5: begin o.alu_op = 2'd0; o.alu_b_sel = 1'b1; end
         3'd6: begin
            o.alu_op = 2'd3;
            o.pc_we  = eq;
            o.pc_src = eq ? 2'd1 : 2'd0;
            o.retire = 1'b1;
         end
         3'd7: begin
`ifdef RISC16_HALT_DETECT_EN
            halted = imm;
`endif
            o.rf_wsel = 2'd3;
            o.pc_src  = 2'd2;
            o.rf_we   = !halted;
            o.pc_we   = !halted;
            o.retire  = 1'b1;
         end
         default: ;
      endcase
      push(i, o);
      if (to_mem) begin
         for (int k = 0; k <= wm; k++) begin
            i = rnd_in(op); i.mem_ready = (k == wm);
            o = quiet(); o.mem_req = 1'b1; o.mem_addr_sel = 1'b1; o.mem_we = (op == 3'd4);
            o.retire = (k == wm) && (op == 3'd4);
            push(i, o);
         end
      end
      if (to_wb || op == 3'd5) begin
         i = rnd_in(op);
         o = quiet(); o.rf_we = 1'b1; o.retire = 1'b1;
         o.rf_wsel = (op == 3'd3) ? 2'd2 : (op == 3'd5) ? 2'd1 : 2'd0;
         push(i, o);
      end
   endtask

   task automatic apply(input vec_t v);
      outs_t act;
      @(negedge clk);
      rst       = v.i.rst;
      mem_ready = v.i.mem_ready;
      opcode    = v.i.opcode;
      alu_eq    = v.i.alu_eq;
      imm_nz    = v.i.imm_nz;
      #1;
      act = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_op,
             alu_b_sel, rf_we, rf_wsel, op_latch, retire, pc_init};
      checks++;
      if (act !== v.o) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h want=%h (rst=%0b ready=%0b op=%0d eq=%0b imm=%0b)",
                  tag, cyc, act, v.o, v.i.rst, v.i.mem_ready, v.i.opcode, v.i.alu_eq, v.i.imm_nz);
      end
      cyc++;
   endtask

   task automatic run_queue(input string name);
      int n;
      n = vq.size();
      tag = name;
      cyc = 0;
      while (vq.size() > 0) apply(vq.pop_front());
      $display("txn %s cycles=%0d checks=%0d failures=%0d", name, n, checks, failures);
   endtask

   dir_t dirs[12];
   ins_t  si;
   outs_t so;

   initial begin
      dirs[0]  = '{3'd0, 0, 0, 1'b0, 1'b0};
      dirs[1]  = '{3'd5, 2, 2, 1'b0, 1'b0};
      dirs[2]  = '{3'd6, 0, 0, 1'b1, 1'b0};
      dirs[3]  = '{3'd6, 0, 0, 1'b0, 1'b0};
      dirs[4]  = '{3'd7, 0, 0, 1'b0, 1'b0};
      dirs[5]  = '{3'd1, 1, 0, 1'b0, 1'b0};
      dirs[6]  = '{3'd2, 0, 0, 1'b1, 1'b0};
      dirs[7]  = '{3'd3, 0, 0, 1'b0, 1'b0};
      dirs[8]  = '{3'd4, 0, 1, 1'b0, 1'b0};
      dirs[9]  = '{3'd4, 0, 0, 1'b1, 1'b0};
      dirs[10] = '{3'd5, 0, 0, 1'b0, 1'b0};
      dirs[11] = '{3'd7, 3, 0, 1'b1, 1'b0};

      for (int k = 0; k < 3; k++) push_reset();
      run_queue("reset");

      for (int k = 0; k < 12; k++) begin
         add_instr(dirs[k].op, dirs[k].wf, dirs[k].wm, dirs[k].eq, dirs[k].imm);
         run_queue($sformatf("dir%0d_op%0d", k, dirs[k].op));
      end

      // Reset during a SW memory wait: request drops immediately, refetch starts at RESET_PC.
      si = rnd_in(3'($urandom)); si.mem_ready = 1'b1;
      so = quiet(); so.mem_req = 1'b1; so.ir_we = 1'b1; so.pc_we = 1'b1;
      push(si, so);
      si = rnd_in(3'd4); so = quiet(); so.op_latch = 1'b1; push(si, so);
      si = rnd_in(3'd4); so = quiet(); so.alu_b_sel = 1'b1; push(si, so);
      si = rnd_in(3'd4); si.mem_ready = 1'b0;
      so = quiet(); so.mem_req = 1'b1; so.mem_we = 1'b1; so.mem_addr_sel = 1'b1;
      push(si, so);
      si = rnd_in(3'd4); si.mem_ready = 1'b0; si.rst = 1'b1;
      so = quiet(); so.pc_we = 1'b1;
      push(si, so);
      add_instr(3'd0, 0, 0, 1'b0, 1'b0);
      run_queue("sw_reset_in_mem");

`ifdef RISC16_HALT_DETECT_EN
      add_instr(3'd7, 0, 0, 1'b0, 1'b1);
      for (int k = 0; k < 20; k++) push(rnd_in(3'($urandom)), quiet());
      push_reset();
      add_instr(3'd0, 0, 0, 1'b0, 1'b0);
      run_queue("jalr_halt");
`endif

      for (int n = 0; n < 150; n++) begin
         logic [2:0] op;
         int         wf;
         int         wm;
         logic       imm;
         op = 3'($urandom_range(0, 7));
         wf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         wm = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
`ifdef RISC16_HALT_DETECT_EN
         imm = 1'b0;
`else
         imm = 1'($urandom);
`endif
         add_instr(op, wf, wm, 1'($urandom), imm);
         run_queue($sformatf("rnd%0d_op%0d_wf%0d_wm%0d", n, op, wf, wm));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
